// File: rtl/load_store_unit.sv
// load_store_unit: sits between execute and data memory. Aligned accesses
// pass straight through; misaligned accesses are either split into byte
// accesses (LSU_MISALIGN_SPLIT_EN defined) or rejected with a fault
// response (LSU_MISALIGN_SPLIT_EN undefined, the default build).
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_unsigned,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_fault,
    output logic [31:0] resp_rdata,
    output logic        mem_write,
    output logic        mem_read,
    output logic        mem_unsigned,
    output logic [2:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    logic        misaligned;
    logic        accept;
    logic        load_pend_reg;   // aligned load waiting for mem_rdata
    logic        resp_valid_reg;
    logic [31:0] resp_rdata_reg;

    // Sizes other than 1 and 2 behave as a word
    always_comb begin
        case (req_size)
            3'd1:    misaligned = 1'b0;
            3'd2:    misaligned = req_addr[0];
            default: misaligned = |req_addr[1:0];
        endcase
    end

    assign accept     = req_valid && req_ready;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SPLIT = 1'b1;

    logic [0:0]  state_reg;
    logic [2:0]  cnt_reg;         // next byte index to issue (N = wait slot)
    logic [2:0]  n_reg;           // bytes in the split access (2 or 4)
    logic [2:0]  cnt_prev;
    logic [31:0] base_reg;
    logic [31:0] wdata_reg;
    logic [31:0] data_reg;        // load bytes captured so far
    logic [31:0] asm_data;
    logic [31:0] ext_data;
    logic        uns_reg;
    logic        write_reg;

    assign req_ready  = rst_n && (state_reg == ST_IDLE);
    assign resp_fault = 1'b0;
    assign cnt_prev   = cnt_reg - 3'd1;

    // Memory port: byte stream while splitting, byte 0 on a misaligned
    // request, otherwise a straight pass-through of the request
    always_comb begin
        mem_write    = 1'b0;
        mem_read     = 1'b0;
        mem_unsigned = 1'b0;
        mem_size     = 3'd0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        if (rst_n) begin
            if (state_reg == ST_SPLIT) begin
                // a load spends one extra slot (cnt == N) waiting for the last byte
                if (cnt_reg < n_reg) begin
                    mem_write = write_reg;
                    mem_read  = !write_reg;
                end
                mem_unsigned = 1'b1;
                mem_size     = 3'd1;
                mem_addr     = base_reg + {29'd0, cnt_reg};
                mem_wdata    = {24'd0, wdata_reg[{cnt_reg[1:0], 3'b000} +: 8]};
            end else if (misaligned) begin
                mem_write    = req_valid && req_write;
                mem_read     = req_valid && !req_write;
                mem_unsigned = 1'b1;
                mem_size     = 3'd1;
                mem_addr     = req_addr;
                mem_wdata    = {24'd0, req_wdata[7:0]};
            end else begin
                mem_write    = req_valid && req_write;
                mem_read     = req_valid && !req_write;
                mem_unsigned = req_unsigned;
                mem_size     = req_size;
                mem_addr     = req_addr;
                mem_wdata    = req_wdata;
            end
        end
    end

    // Merge the byte arriving now with earlier ones, then extend a halfword
    always_comb begin
        asm_data = data_reg;
        asm_data[{cnt_prev[1:0], 3'b000} +: 8] = mem_rdata[7:0];
        if (n_reg == 3'd2)
            ext_data = uns_reg ? {16'd0, asm_data[15:0]}
                               : {{16{asm_data[15]}}, asm_data[15:0]};
        else
            ext_data = asm_data;
    end

    // Control FSM, byte capture and response generation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= 3'd0;
            n_reg          <= 3'd0;
            base_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
            data_reg       <= 32'd0;
            uns_reg        <= 1'b0;
            write_reg      <= 1'b0;
            load_pend_reg  <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 32'd0;
        end else begin
            // A store accepted the cycle after an aligned load shares its pulse
            resp_valid_reg <= load_pend_reg;
            resp_rdata_reg <= load_pend_reg ? mem_rdata : 32'd0;
            load_pend_reg  <= 1'b0;
            if (state_reg == ST_IDLE) begin
                if (accept) begin
                    if (misaligned) begin
                        state_reg <= ST_SPLIT;
                        cnt_reg   <= 3'd1;
                        n_reg     <= (req_size == 3'd2) ? 3'd2 : 3'd4;
                        base_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        data_reg  <= 32'd0;
                        uns_reg   <= req_unsigned;
                        write_reg <= req_write;
                    end else if (req_write) begin
                        resp_valid_reg <= 1'b1;
                    end else begin
                        load_pend_reg <= 1'b1;
                    end
                end
            end else begin
                cnt_reg <= cnt_reg + 3'd1;
                if (!write_reg)
                    data_reg[{cnt_prev[1:0], 3'b000} +: 8] <= mem_rdata[7:0];
                if (write_reg && (cnt_reg == n_reg - 3'd1)) begin
                    state_reg      <= ST_IDLE;
                    resp_valid_reg <= 1'b1;
                end
                if (!write_reg && (cnt_reg == n_reg)) begin
                    state_reg      <= ST_IDLE;
                    resp_valid_reg <= 1'b1;
                    resp_rdata_reg <= ext_data;
                end
            end
        end
    end
`else
    logic resp_fault_reg;

    assign req_ready  = rst_n;
    assign resp_fault = resp_fault_reg;

    // Pass-through; misaligned requests never reach memory
    always_comb begin
        mem_write    = 1'b0;
        mem_read     = 1'b0;
        mem_unsigned = 1'b0;
        mem_size     = 3'd0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        if (rst_n) begin
            mem_write    = req_valid && req_write && !misaligned;
            mem_read     = req_valid && !req_write && !misaligned;
            mem_unsigned = req_unsigned;
            mem_size     = req_size;
            mem_addr     = req_addr;
            mem_wdata    = req_wdata;
        end
    end

    // Response generation: immediate for stores and faults, delayed for loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_pend_reg  <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_fault_reg <= 1'b0;
            resp_rdata_reg <= 32'd0;
        end else begin
            resp_valid_reg <= load_pend_reg;
            resp_rdata_reg <= load_pend_reg ? mem_rdata : 32'd0;
            resp_fault_reg <= 1'b0;
            load_pend_reg  <= 1'b0;
            if (accept) begin
                if (misaligned) begin
                    resp_valid_reg <= 1'b1;
                    resp_fault_reg <= 1'b1;
                end else if (req_write) begin
                    resp_valid_reg <= 1'b1;
                end else begin
                    load_pend_reg <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array memory as the
// environment, separate byte-array reference model for expected results.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic        mem_write, mem_read, mem_unsigned;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_b [0:255];   // environment memory
    logic [7:0]  ref_b [0:255];   // reference model contents
    logic [32:0] acc_q [$];       // {write, addr} of each memory access

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_unsigned(req_unsigned), .req_size(req_size), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_fault(resp_fault), .resp_rdata(resp_rdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_unsigned(mem_unsigned),
        .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sz2n(input logic [2:0] sz);
        if (sz == 3'd1) return 1;
        if (sz == 3'd2) return 2;
        return 4;
    endfunction

    // Memory: samples strobes at the edge, read data valid the next cycle
    always @(posedge clk) begin
        logic [31:0] v;
        logic [31:0] a;
        int n;
        n = sz2n(mem_size);
        if (mem_write || mem_read)
            acc_q.push_back({mem_write, mem_addr});
        if (mem_write) begin
            for (int i = 0; i < n; i++) begin
                a = mem_addr + i;
                mem_b[a[7:0]] = mem_wdata[8*i +: 8];
            end
        end
        if (mem_read) begin
            v = 32'd0;
            for (int i = 0; i < n; i++) begin
                a = mem_addr + i;
                v[8*i +: 8] = mem_b[a[7:0]];
            end
            if (!mem_unsigned && n == 1) v = {{24{v[7]}}, v[7:0]};
            if (!mem_unsigned && n == 2) v = {{16{v[15]}}, v[15:0]};
            mem_rdata <= v;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One request from a negedge; checks response timing, data, fault,
    // ready and the memory access sequence against the reference model.
    task automatic do_req(input bit wr, input bit uns, input logic [2:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] got);
        int n, lat, nacc;
        bit mis, flt;
        logic [31:0] exp_d, a;
        logic [32:0] exp_acc [$];
        n   = sz2n(sz);
        mis = (n > 1) && ((addr & (n - 1)) != 0);
        flt = mis && !SPLIT;
        exp_d = 32'd0;
        if (!wr && !flt) begin
            for (int i = 0; i < n; i++) begin
                a = addr + i;
                exp_d[8*i +: 8] = ref_b[a[7:0]];
            end
            if (!uns && n == 1) exp_d = {{24{exp_d[7]}}, exp_d[7:0]};
            if (!uns && n == 2) exp_d = {{16{exp_d[15]}}, exp_d[15:0]};
        end
        if (flt)      lat = 0;
        else if (!mis) lat = wr ? 0 : 1;
        else           lat = wr ? n - 1 : n;
        nacc = flt ? 0 : (mis ? n : 1);
        for (int i = 0; i < nacc; i++) exp_acc.push_back({wr, addr + i});
        if (wr && !flt) begin
            for (int i = 0; i < n; i++) begin
                a = addr + i;
                ref_b[a[7:0]] = wd[8*i +: 8];
            end
        end

        chk("ready_before", req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_unsigned = uns;
        req_size = sz; req_addr = addr; req_wdata = wd;
        acc_q.delete();
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        got = 32'd0;
        for (int k = 0; k <= lat + 1; k++) begin
            if (k > 0) @(negedge clk);
            chk("resp_valid", resp_valid, (k == lat));
            if (k == lat) begin
                got = resp_rdata;
                chk("resp_rdata", resp_rdata, exp_d);
                chk("resp_fault", resp_fault, flt);
            end
            if (k < lat) chk("req_ready_busy", req_ready, !(mis && SPLIT));
        end
        chk("acc_count", acc_q.size(), exp_acc.size());
        for (int i = 0; i < nacc && i < acc_q.size(); i++)
            chk("acc_addr", acc_q[i], exp_acc[i]);
        $display("txn %s size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h fault=%0d",
                 wr ? "st" : "ld", sz, uns, addr, wd, got, flt);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] init_w0, init_w4;
        init_w0 = 32'h88776655;
        init_w4 = 32'hCCBBAA99;
        for (int i = 0; i < 256; i++) begin
            mem_b[i] = 8'($urandom);
            ref_b[i] = mem_b[i];
        end
        for (int i = 0; i < 4; i++) begin
            mem_b[i] = init_w0[8*i +: 8]; ref_b[i] = mem_b[i];
            mem_b[4+i] = init_w4[8*i +: 8]; ref_b[4+i] = mem_b[4+i];
        end
        mem_rdata = 32'd0;

        // Reset state, with an active request present
        rst_n = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_unsigned = 1'b1;
        req_size = 3'd4; req_addr = 32'hDEADBEEF; req_wdata = 32'h12345678;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_fault", resp_fault, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_mem_read", mem_read, 0);

        // Test plan loads
        do_req(0, 0, 3'd4, 32'd0, 32'd0, got); chk("lw0", got, 32'h88776655);
        do_req(0, 0, 3'd2, 32'd2, 32'd0, got); chk("lh2", got, 32'hFFFF8877);
        do_req(0, 1, 3'd2, 32'd2, 32'd0, got); chk("lhu2", got, 32'h00008877);
        do_req(0, 0, 3'd1, 32'd3, 32'd0, got); chk("lb3", got, 32'hFFFFFF88);

        // lw addr 1 abandoned by a reset pulse at t0+2
        req_valid = 1'b1; req_write = 1'b0; req_unsigned = 1'b0;
        req_size = 3'd4; req_addr = 32'd1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_read_before", mem_read, SPLIT);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_mem_read", mem_read, 0);
        chk("abort_req_ready", req_ready, 0);
        chk("abort_resp_valid", resp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("abort_no_resp", resp_valid, 0);
        end
        do_req(0, 0, 3'd4, 32'd0, 32'd0, got); chk("lw0_after_rst", got, 32'h88776655);

`ifdef LSU_MISALIGN_SPLIT_EN
        do_req(0, 0, 3'd4, 32'd3, 32'd0, got);        chk("lw3_split", got, 32'hBBAA9988);
        do_req(1, 0, 3'd2, 32'd3, 32'h00001234, got); chk("sh3_rdata", got, 32'h0);
        do_req(0, 0, 3'd4, 32'd0, 32'd0, got);        chk("lw0_after_sh", got, 32'h34776655);
        do_req(0, 0, 3'd4, 32'd4, 32'd0, got);        chk("lw4_after_sh", got, 32'hCCBBAA12);
`else
        do_req(0, 0, 3'd4, 32'd1, 32'd0, got);        chk("lw1_fault_rdata", got, 32'h0);
`endif

        // Address wrap at the top of the address space
        do_req(0, 0, 3'd2, 32'hFFFFFFFF, 32'd0, got);
        do_req(1, 0, 3'd4, 32'hFFFFFFFE, 32'hA5C3_1E77, got);
        do_req(0, 1, 3'd4, 32'hFFFFFFFE, 32'd0, got);

        // Randomized mix of sizes, alignments and directions
        for (int t = 0; t < 80; t++) begin
            do_req(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 48)), $urandom, got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
